// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch conditions against the committed {N,V,Z}
// flags, stalls one cycle when EX is writing flags, and counts resolved/taken branches.
module branch_resolve_unit #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned OFFSET_W = 9,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                br_valid,
   input  logic                br_reg,
   input  logic [2:0]          cond,
   input  logic [ADDR_W-1:0]   pc_next,
   input  logic [OFFSET_W-1:0] offset,
   input  logic [ADDR_W-1:0]   reg_target,
   input  logic [2:0]          flag_current,
   input  logic [2:0]          ex_flag_wen,
   input  logic                flush,
   output logic                br_stall,
   output logic                br_done,
   output logic                br_taken,
   output logic [ADDR_W-1:0]   br_target,
   output logic [CNT_W-1:0]    br_cnt,
   output logic [CNT_W-1:0]    taken_cnt
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t                state;
   state_t                state_next;
   logic                  hazard;
   logic                  capture;
   logic                  done_next;
   logic                  taken_next;
   logic [ADDR_W-1:0]     target_next;

   logic                  cap_reg;
   logic [2:0]            cap_cond;
   logic [ADDR_W-1:0]     cap_pc;
   logic [OFFSET_W-1:0]   cap_off;
   logic [ADDR_W-1:0]     cap_rt;

   // Condition decode on flags {N,V,Z}
   function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
      logic n;
      logic v;
      logic z;
      logic r;
      n = f[2];
      v = f[1];
      z = f[0];
      case (c)
         3'b000:  r = ~z;
         3'b001:  r = z;
         3'b010:  r = ~z & ~n;
         3'b011:  r = n;
         3'b100:  r = z | ~n;
         3'b101:  r = n | z;
         3'b110:  r = v;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   // Register target, or PC-relative word offset (wraps modulo 2^ADDR_W)
   function automatic logic [ADDR_W-1:0] calc_target(input logic                is_reg,
                                                     input logic [ADDR_W-1:0]   pc,
                                                     input logic [OFFSET_W-1:0] off,
                                                     input logic [ADDR_W-1:0]   rt);
      logic [ADDR_W-1:0] off_sx;
      off_sx = ADDR_W'($signed(off));
      return is_reg ? rt : pc + {off_sx[ADDR_W-2:0], 1'b0};
   endfunction

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state, capture enable and resolution result
   always_comb begin
      state_next  = state;
      hazard      = |ex_flag_wen;
      capture     = 1'b0;
      done_next   = 1'b0;
      taken_next  = 1'b0;
      target_next = br_target;
      case (state)
         IDLE: begin
            if (!flush && br_valid) begin
               capture = 1'b1;
               if (hazard) begin
                  state_next = HOLD;
               end else begin
                  done_next   = 1'b1;
                  taken_next  = cond_met(cond, flag_current);
                  target_next = calc_target(br_reg, pc_next, offset, reg_target);
               end
            end
         end
         HOLD: begin
            state_next = IDLE;
            if (!flush) begin
               done_next   = 1'b1;
               taken_next  = cond_met(cap_cond, flag_current);
               target_next = calc_target(cap_reg, cap_pc, cap_off, cap_rt);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Stall fetch/decode while waiting for in-flight flags to commit
   assign br_stall = (state == HOLD) |
                     ((state == IDLE) & br_valid & (|ex_flag_wen) & ~flush);

   // Capture the accepted branch for resolution in HOLD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_reg  <= 1'b0;
         cap_cond <= 3'b000;
         cap_pc   <= '0;
         cap_off  <= '0;
         cap_rt   <= '0;
      end else if (capture) begin
         cap_reg  <= br_reg;
         cap_cond <= cond;
         cap_pc   <= pc_next;
         cap_off  <= offset;
         cap_rt   <= reg_target;
      end
   end

   // Registered resolution outputs; target holds between pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_done   <= 1'b0;
         br_taken  <= 1'b0;
         br_target <= '0;
      end else begin
         br_done   <= done_next;
         br_taken  <= taken_next;
         br_target <= target_next;
      end
   end

   // Saturating statistics, updated together with the resolution pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt    <= '0;
         taken_cnt <= '0;
      end else if (done_next) begin
         if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
         if (taken_next && (taken_cnt != '1)) taken_cnt <= taken_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver pushes expected resolutions,
// a negedge monitor pops and compares on every br_done pulse.
module tb_branch_resolve_unit;

   localparam int unsigned ADDR_W   = 16;
   localparam int unsigned OFFSET_W = 9;
   localparam int unsigned CNT_W    = 16;

   logic                clk;
   logic                rst;
   logic                br_valid;
   logic                br_reg;
   logic [2:0]          cond;
   logic [ADDR_W-1:0]   pc_next;
   logic [OFFSET_W-1:0] offset;
   logic [ADDR_W-1:0]   reg_target;
   logic [2:0]          flag_current;
   logic [2:0]          ex_flag_wen;
   logic                flush;
   logic                br_stall;
   logic                br_done;
   logic                br_taken;
   logic [ADDR_W-1:0]   br_target;
   logic [CNT_W-1:0]    br_cnt;
   logic [CNT_W-1:0]    taken_cnt;
   logic                s2_stall;
   logic                s2_done;
   logic                s2_taken;
   logic [ADDR_W-1:0]   s2_target;
   logic [1:0]          s2_br_cnt;
   logic [1:0]          s2_taken_cnt;

   typedef struct packed {
      logic              taken;
      logic [ADDR_W-1:0] target;
   } exp_t;

   exp_t              q[$];
   int                errors = 0;
   int                checks = 0;
   int                n_br = 0;
   int                n_tk = 0;
   logic [ADDR_W-1:0] last_target = '0;

   // model state for the pending hazard branch
   bit                  in_hold = 0;
   logic                h_reg;
   logic [2:0]          h_cond;
   logic [ADDR_W-1:0]   h_pc;
   logic [OFFSET_W-1:0] h_off;
   logic [ADDR_W-1:0]   h_rt;

   branch_resolve_unit #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_reg(br_reg), .cond(cond),
      .pc_next(pc_next), .offset(offset), .reg_target(reg_target),
      .flag_current(flag_current), .ex_flag_wen(ex_flag_wen), .flush(flush),
      .br_stall(br_stall), .br_done(br_done), .br_taken(br_taken),
      .br_target(br_target), .br_cnt(br_cnt), .taken_cnt(taken_cnt));

   branch_resolve_unit #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_reg(br_reg), .cond(cond),
      .pc_next(pc_next), .offset(offset), .reg_target(reg_target),
      .flag_current(flag_current), .ex_flag_wen(ex_flag_wen), .flush(flush),
      .br_stall(s2_stall), .br_done(s2_done), .br_taken(s2_taken),
      .br_target(s2_target), .br_cnt(s2_br_cnt), .taken_cnt(s2_taken_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int n, input int mx);
      return (n > mx) ? mx : n;
   endfunction

   // Reference: condition table and target arithmetic written directly from the rules
   function automatic exp_t ref_eval(input logic r, input logic [2:0] c, input logic [ADDR_W-1:0] pc,
                                     input logic [OFFSET_W-1:0] off, input logic [ADDR_W-1:0] rt,
                                     input logic [2:0] f);
      exp_t e;
      bit   n, v, z;
      int   t;
      n = f[2];
      v = f[1];
      z = f[0];
      case (c)
         3'd0:    e.taken = !z;
         3'd1:    e.taken = z;
         3'd2:    e.taken = !z && !n;
         3'd3:    e.taken = n;
         3'd4:    e.taken = z || !n;
         3'd5:    e.taken = n || z;
         3'd6:    e.taken = v;
         default: e.taken = 1'b1;
      endcase
      if (r) begin
         e.target = rt;
      end else begin
         t = int'(pc) + 2 * int'($signed(off));
         e.target = t[ADDR_W-1:0];
      end
      return e;
   endfunction

   // Drive one cycle of inputs at posedge+1, update the model, advance one clock
   task automatic step(input logic v, input logic r, input logic [2:0] c, input logic [ADDR_W-1:0] pc,
                       input logic [OFFSET_W-1:0] off, input logic [ADDR_W-1:0] rt,
                       input logic [2:0] wen, input logic [2:0] wval, input logic fl);
      bit   was_hold;
      logic exp_stall;
      br_valid    = v;
      br_reg      = r;
      cond        = c;
      pc_next     = pc;
      offset      = off;
      reg_target  = rt;
      ex_flag_wen = wen;
      flush       = fl;
      was_hold    = in_hold;
      exp_stall   = in_hold || (v && (wen != 3'b000) && !fl);
      #1;
      chk("br_stall", 32'(br_stall), 32'(exp_stall));
      if (in_hold) begin
         if (!fl) q.push_back(ref_eval(h_reg, h_cond, h_pc, h_off, h_rt, flag_current));
         in_hold = 0;
      end else if (v && !fl) begin
         if (wen == 3'b000) begin
            q.push_back(ref_eval(r, c, pc, off, rt, flag_current));
         end else begin
            h_reg = r; h_cond = c; h_pc = pc; h_off = off; h_rt = rt;
            in_hold = 1;
         end
      end
      @(posedge clk);
      #1;
      if (!was_hold) flag_current = (flag_current & ~wen) | (wval & wen);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 3'd0, '0, '0, '0, 3'b000, 3'b000, 0);
   endtask

   task automatic check_counters(input string tag);
      chk({tag, "_br_cnt"},    32'(br_cnt),       32'(sat(n_br, 65535)));
      chk({tag, "_taken_cnt"}, 32'(taken_cnt),    32'(sat(n_tk, 65535)));
      chk({tag, "_sat_br"},    32'(s2_br_cnt),    32'(sat(n_br, 3)));
      chk({tag, "_sat_taken"}, 32'(s2_taken_cnt), 32'(sat(n_tk, 3)));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_done"},   32'(br_done),   32'd0);
      chk({tag, "_taken"},  32'(br_taken),  32'd0);
      chk({tag, "_target"}, 32'(br_target), 32'd0);
      chk({tag, "_br_cnt"}, 32'(br_cnt),    32'd0);
      chk({tag, "_tk_cnt"}, 32'(taken_cnt), 32'd0);
   endtask

   task automatic model_reset();
      q.delete();
      n_br = 0;
      n_tk = 0;
      last_target = '0;
      in_hold = 0;
   endtask

   // Monitor: pop and compare on each resolution pulse; quiet cycles must hold outputs
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (br_done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("br_taken", 32'(br_taken), 32'(e.taken));
               chk("br_target", 32'(br_target), 32'(e.target));
               n_br++;
               if (e.taken) n_tk++;
               last_target = e.target;
            end
         end else begin
            chk("taken_idle", 32'(br_taken), 32'd0);
            chk("target_hold", 32'(br_target), 32'(last_target));
         end
      end
   end

   initial begin
      rst = 1'b1;
      br_valid = 0; br_reg = 0; cond = '0; pc_next = '0; offset = '0; reg_target = '0;
      flag_current = 3'b000; ex_flag_wen = '0; flush = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      chk("reset_stall", 32'(br_stall), 32'd0);
      rst = 1'b0;

      // EQ taken, backward offset
      flag_current = 3'b001;
      step(1, 0, 3'd1, 16'h0010, 9'h1FE, 16'h0000, 3'b000, 3'b000, 0);
      idle(2);
      // EQ with in-flight Z write: stall two cycles, taken
      flag_current = 3'b000;
      step(1, 0, 3'd1, 16'h0020, 9'h004, 16'h0000, 3'b001, 3'b001, 0);
      step(0, 0, 3'd0, '0, '0, '0, 3'b000, 3'b000, 0);
      idle(2);
      // Always, register target
      step(1, 1, 3'd7, 16'h1234, 9'h000, 16'hBEEF, 3'b000, 3'b000, 0);
      idle(2);
      // GT with N set: not taken
      flag_current = 3'b100;
      step(1, 0, 3'd2, 16'h0100, 9'h010, 16'h0000, 3'b000, 3'b000, 0);
      idle(2);
      check_counters("directed");
      // Flush while held: nothing resolves
      step(1, 0, 3'd7, 16'h0200, 9'h001, 16'h0000, 3'b010, 3'b010, 0);
      step(0, 0, 3'd0, '0, '0, '0, 3'b000, 3'b000, 1);
      idle(3);
      check_counters("flush_hold");
      // Flush in IDLE with a valid branch: not accepted
      step(1, 0, 3'd7, 16'h0300, 9'h001, 16'h0000, 3'b000, 3'b000, 1);
      idle(2);
      check_counters("flush_idle");
      // Reset during HOLD
      step(1, 1, 3'd7, 16'h0000, 9'h000, 16'hCAFE, 3'b100, 3'b100, 0);
      rst = 1'b1;
      model_reset();
      br_valid = 0; ex_flag_wen = '0;
      #1;
      check_zero("rst_hold");
      chk("rst_hold_stall", 32'(br_stall), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(3);
      // Five back-to-back taken branches saturate the 2-bit counters
      for (int i = 0; i < 5; i++)
         step(1, 0, 3'd7, 16'(16'h0400 + 16'(i * 2)), 9'h003, 16'h0000, 3'b000, 3'b000, 0);
      idle(2);
      check_counters("sat5");

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic       v, r, fl;
         logic [2:0] wen;
         v   = ($urandom_range(0, 9) < 6);
         r   = 1'($urandom);
         fl  = ($urandom_range(0, 9) == 0);
         wen = ($urandom_range(0, 9) < 3) ? 3'($urandom) : 3'b000;
         step(v, r, 3'($urandom), 16'($urandom), 9'($urandom), 16'($urandom), wen, 3'($urandom), fl);
      end
      idle(3);
      chk("queue_drained", 32'(q.size()), 32'd0);
      check_counters("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
